// File: rtl/mdu_unit.sv
// Multiply/divide unit: 1-cycle MUL path, 32-step restoring divider plus a sign-fixup cycle, HI/LO registers.
// Optional MADD/MADDU/MSUB/MSUBU accumulate ops are built only when MDU_MADD_EN is defined.
module mdu_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [3:0]  ALU2Op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        flush,
  output logic        isbusy,
  output logic        done,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] mul_result,
  output logic [1:0]  dbg_state
);

  localparam logic [3:0] OP_MULT  = 4'b0001;
  localparam logic [3:0] OP_MULTU = 4'b0010;
  localparam logic [3:0] OP_DIV   = 4'b0011;
  localparam logic [3:0] OP_DIVU  = 4'b0100;
  localparam logic [3:0] OP_MTHI  = 4'b0101;
  localparam logic [3:0] OP_MTLO  = 4'b0110;
  localparam logic [3:0] OP_MUL   = 4'b1000;
`ifdef MDU_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'b1001;
  localparam logic [3:0] OP_MADDU = 4'b1010;
  localparam logic [3:0] OP_MSUB  = 4'b1011;
  localparam logic [3:0] OP_MSUBU = 4'b1100;
`endif

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_DIV = 2'd2, S_FIX = 2'd3} state_t;

  // Handshake: start is taken only in S_IDLE with flush low; there is no ready,
  // the stall unit must hold EX while isbusy is high.
  state_t      state_q, state_d;
  logic [31:0] a_q, a_d, b_q, b_d, rem_q, rem_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d, mulr_q, mulr_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [3:0]  op_q, op_d;
  logic        neg_q, neg_d, rsgn_q, rsgn_d, done_q, done_d;

  logic        mul_sgn;
  logic [63:0] ext_a, ext_b, prod;
  logic [32:0] trial;

  always_comb begin
    mul_sgn = (op_q == OP_MULT) || (op_q == OP_MUL);
`ifdef MDU_MADD_EN
    if ((op_q == OP_MADD) || (op_q == OP_MSUB)) mul_sgn = 1'b1;
`endif
    ext_a = {{32{mul_sgn & a_q[31]}}, a_q};
    ext_b = {{32{mul_sgn & b_q[31]}}, b_q};
    prod  = ext_a * ext_b;
    // a_q doubles as the dividend/quotient shift register during S_DIV
    trial = {rem_q, a_q[31]} - {1'b0, b_q};
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    rem_d   = rem_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    mulr_d  = mulr_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    neg_d   = neg_q;
    rsgn_d  = rsgn_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && !flush) begin
          case (ALU2Op)
`ifdef MDU_MADD_EN
            OP_MULT, OP_MULTU, OP_MUL, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: begin
`else
            OP_MULT, OP_MULTU, OP_MUL: begin
`endif
              a_d     = A;
              b_d     = B;
              op_d    = ALU2Op;
              state_d = S_MUL;
            end
            OP_DIV, OP_DIVU: begin
              a_d     = (ALU2Op == OP_DIV && A[31]) ? -A : A;
              b_d     = (ALU2Op == OP_DIV && B[31]) ? -B : B;
              neg_d   = (ALU2Op == OP_DIV) && (A[31] ^ B[31]);
              rsgn_d  = (ALU2Op == OP_DIV) && A[31];
              op_d    = ALU2Op;
              rem_d   = '0;
              cnt_d   = '0;
              state_d = S_DIV;
            end
            OP_MTHI: hi_d = A;
            OP_MTLO: lo_d = A;
            default: ;
          endcase
        end
      end
      S_MUL: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        case (op_q)
          OP_MUL: mulr_d = prod[31:0];
`ifdef MDU_MADD_EN
          OP_MADD, OP_MADDU: {hi_d, lo_d} = {hi_q, lo_q} + prod;
          OP_MSUB, OP_MSUBU: {hi_d, lo_d} = {hi_q, lo_q} - prod;
`endif
          default: {hi_d, lo_d} = prod;
        endcase
      end
      S_DIV: begin
        if (!trial[32]) rem_d = trial[31:0];
        else            rem_d = {rem_q[30:0], a_q[31]};
        a_d   = {a_q[30:0], ~trial[32]};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = S_FIX;
      end
      S_FIX: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        // a zero divisor still runs the full sequence but commits nothing
        if (b_q != 32'd0) begin
          lo_d = neg_q ? -a_q : a_q;
          hi_d = rsgn_q ? -rem_q : rem_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (flush) begin
      state_d = S_IDLE;
      done_d  = 1'b0;
      hi_d    = hi_q;
      lo_d    = lo_q;
      mulr_d  = mulr_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      rem_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      mulr_q  <= '0;
      cnt_q   <= '0;
      op_q    <= '0;
      neg_q   <= 1'b0;
      rsgn_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rem_q   <= rem_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      mulr_q  <= mulr_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
      rsgn_q  <= rsgn_d;
      done_q  <= done_d;
    end
  end

  assign isbusy     = (state_q != S_IDLE);
  assign done       = done_q;
  assign HI         = hi_q;
  assign LO         = lo_q;
  assign mul_result = mulr_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_mdu_unit.sv
// Directed bench for mdu_unit: inputs driven and outputs sampled on the falling clock edge.
module tb_mdu_unit;

  localparam logic [3:0] OP_MULT  = 4'b0001;
  localparam logic [3:0] OP_MULTU = 4'b0010;
  localparam logic [3:0] OP_DIV   = 4'b0011;
  localparam logic [3:0] OP_DIVU  = 4'b0100;
  localparam logic [3:0] OP_MTHI  = 4'b0101;
  localparam logic [3:0] OP_MTLO  = 4'b0110;
  localparam logic [3:0] OP_MUL   = 4'b1000;
  localparam logic [3:0] OP_MADDU = 4'b1010;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  ALU2Op = '0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic        flush = 1'b0;
  logic        isbusy, done;
  logic [31:0] HI, LO, mul_result;
  logic [1:0]  dbg_state;

  int total = 0;
  int bad = 0;

  mdu_unit dut (
    .clk(clk), .rst(rst), .start(start), .ALU2Op(ALU2Op), .A(A), .B(B), .flush(flush),
    .isbusy(isbusy), .done(done), .HI(HI), .LO(LO), .mul_result(mul_result), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // Present one start for one cycle; returns on the falling edge after the accepting edge.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; ALU2Op = op; A = a; B = b;
    @(negedge clk);
    start = 1'b0; ALU2Op = '0; A = '0; B = '0;
  endtask

  // Counts busy cycles until idle, bounded so a stuck DUT cannot hang the run.
  task automatic wait_idle(output int n);
    n = 0;
    while (isbusy && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    #3;
    total++; if (isbusy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", isbusy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
    total++; if (HI !== 32'h0 || LO !== 32'h0) begin bad++; $display("FAIL reset_hilo: got %h:%h want 0:0", HI, LO); end
    total++; if (mul_result !== 32'h0) begin bad++; $display("FAIL reset_mulr: got %h want 0", mul_result); end
    total++; if (dbg_state !== 2'd0) begin bad++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_mult;
    int n;
    issue(OP_MULT, 32'hFFFFFFFE, 32'd3);
    wait_idle(n);
    total++; if (n !== 1) begin bad++; $display("FAIL mult_busy: got %0d want 1", n); end
    total++; if (done !== 1'b1) begin bad++; $display("FAIL mult_done: got %b want 1", done); end
    total++; if (HI !== 32'hFFFFFFFF || LO !== 32'hFFFFFFFA) begin bad++; $display("FAIL mult_hilo: got %h:%h want ffffffff:fffffffa", HI, LO); end
    @(negedge clk);
    total++; if (done !== 1'b0) begin bad++; $display("FAIL mult_done_pulse: got %b want 0", done); end
  endtask

  task automatic test_mul;
    int n;
    issue(OP_MUL, 32'h00010000, 32'h00010003);
    wait_idle(n);
    total++; if (n !== 1 || done !== 1'b1) begin bad++; $display("FAIL mul_busy_done: got %0d/%b want 1/1", n, done); end
    total++; if (mul_result !== 32'h00030000) begin bad++; $display("FAIL mul_result: got %h want 00030000", mul_result); end
    total++; if (HI !== 32'hFFFFFFFF || LO !== 32'hFFFFFFFA) begin bad++; $display("FAIL mul_hilo_kept: got %h:%h want ffffffff:fffffffa", HI, LO); end
  endtask

  task automatic test_multu;
    int n;
    issue(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_idle(n);
    total++; if (HI !== 32'hFFFFFFFE || LO !== 32'h00000001) begin bad++; $display("FAIL multu_hilo: got %h:%h want fffffffe:00000001", HI, LO); end
  endtask

  task automatic test_div;
    int n;
    issue(OP_DIV, 32'hFFFFFFF9, 32'd2);
    wait_idle(n);
    total++; if (n !== 33) begin bad++; $display("FAIL div_busy: got %0d want 33", n); end
    total++; if (done !== 1'b1) begin bad++; $display("FAIL div_done: got %b want 1", done); end
    total++; if (LO !== 32'hFFFFFFFD || HI !== 32'hFFFFFFFF) begin bad++; $display("FAIL div_neg: got hi=%h lo=%h want ffffffff/fffffffd", HI, LO); end
    issue(OP_DIV, 32'd7, 32'hFFFFFFFE);
    wait_idle(n);
    total++; if (LO !== 32'hFFFFFFFD || HI !== 32'h1) begin bad++; $display("FAIL div_negb: got hi=%h lo=%h want 1/fffffffd", HI, LO); end
    issue(OP_DIV, 32'h80000000, 32'hFFFFFFFF);
    wait_idle(n);
    total++; if (LO !== 32'h80000000 || HI !== 32'h0) begin bad++; $display("FAIL div_wrap: got hi=%h lo=%h want 0/80000000", HI, LO); end
    issue(OP_DIVU, 32'd100, 32'd7);
    wait_idle(n);
    total++; if (LO !== 32'd14 || HI !== 32'd2) begin bad++; $display("FAIL divu: got hi=%h lo=%h want 2/e", HI, LO); end
  endtask

  task automatic test_div_zero;
    int n;
    issue(OP_MTHI, 32'h11, 32'h0);
    total++; if (HI !== 32'h11 || isbusy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL mthi: got hi=%h busy=%b done=%b want 11/0/0", HI, isbusy, done); end
    issue(OP_MTLO, 32'h22, 32'h0);
    total++; if (LO !== 32'h22) begin bad++; $display("FAIL mtlo: got %h want 22", LO); end
    issue(OP_DIVU, 32'd100, 32'd0);
    wait_idle(n);
    total++; if (n !== 33 || done !== 1'b1) begin bad++; $display("FAIL div0_busy_done: got %0d/%b want 33/1", n, done); end
    total++; if (HI !== 32'h11 || LO !== 32'h22) begin bad++; $display("FAIL div0_hilo: got %h:%h want 11:22", HI, LO); end
  endtask

  task automatic test_busy_ignore;
    int n;
    issue(OP_DIVU, 32'd100, 32'd7);
    issue(OP_MTLO, 32'h55, 32'h0);
    total++; if (LO !== 32'h22 || isbusy !== 1'b1) begin bad++; $display("FAIL busy_ignore: got lo=%h busy=%b want 22/1", LO, isbusy); end
    wait_idle(n);
    total++; if (LO !== 32'd14 || HI !== 32'd2) begin bad++; $display("FAIL busy_ignore_result: got %h:%h want 2:e", HI, LO); end
  endtask

  task automatic test_flush;
    int n;
    logic seen;
    issue(OP_DIVU, 32'd100, 32'd7);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    total++; if (isbusy !== 1'b0 || dbg_state !== 2'd0) begin bad++; $display("FAIL flush_idle: got busy=%b state=%0d want 0/0", isbusy, dbg_state); end
    seen = 1'b0;
    repeat (40) begin
      if (done) seen = 1'b1;
      @(negedge clk);
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL flush_no_done: got %b want 0", seen); end
    total++; if (HI !== 32'd2 || LO !== 32'd14) begin bad++; $display("FAIL flush_hilo: got %h:%h want 2:e", HI, LO); end
    issue(OP_MULTU, 32'd5, 32'd6);
    wait_idle(n);
    total++; if (LO !== 32'd30 || HI !== 32'd0) begin bad++; $display("FAIL flush_then_multu: got %h:%h want 0:1e", HI, LO); end
    // flush landing on the fixup cycle must beat its commit
    issue(OP_DIV, 32'hFFFFFFF9, 32'd2);
    repeat (32) @(negedge clk);
    total++; if (dbg_state !== 2'd3) begin bad++; $display("FAIL fix_state: got %0d want 3", dbg_state); end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    total++; if (done !== 1'b0 || isbusy !== 1'b0 || LO !== 32'd30 || HI !== 32'd0) begin bad++; $display("FAIL flush_fix: got done=%b busy=%b hilo=%h:%h want 0/0/0:1e", done, isbusy, HI, LO); end
  endtask

  task automatic test_reset_mid;
    issue(OP_DIVU, 32'd100, 32'd7);
    repeat (19) @(negedge clk);
    rst = 1'b0;
    #1;
    total++; if (isbusy !== 1'b0 || done !== 1'b0 || HI !== 32'h0 || LO !== 32'h0 || mul_result !== 32'h0) begin
      bad++; $display("FAIL rst_mid: got busy=%b done=%b hi=%h lo=%h mulr=%h want all 0", isbusy, done, HI, LO, mul_result);
    end
    @(negedge clk);
    rst = 1'b1; start = 1'b1; ALU2Op = OP_MTLO; A = 32'hABCD;
    @(negedge clk);
    start = 1'b0; ALU2Op = '0; A = '0;
    total++; if (LO !== 32'hABCD) begin bad++; $display("FAIL rst_then_mtlo: got %h want abcd", LO); end
  endtask

  task automatic test_madd;
    int n;
    issue(OP_MTHI, 32'h0, 32'h0);
    issue(OP_MTLO, 32'hFFFFFFFF, 32'h0);
    issue(OP_MADDU, 32'd1, 32'd1);
`ifdef MDU_MADD_EN
    wait_idle(n);
    total++; if (n !== 1 || done !== 1'b1) begin bad++; $display("FAIL maddu_busy_done: got %0d/%b want 1/1", n, done); end
    total++; if (HI !== 32'h1 || LO !== 32'h0) begin bad++; $display("FAIL maddu_hilo: got %h:%h want 1:0", HI, LO); end
`else
    n = 0;
    total++; if (isbusy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL maddu_noop_busy: got %b/%b want 0/0", isbusy, done); end
    @(negedge clk);
    total++; if (HI !== 32'h0 || LO !== 32'hFFFFFFFF) begin bad++; $display("FAIL maddu_noop_hilo: got %h:%h want 0:ffffffff", HI, LO); end
`endif
  endtask

  initial begin
    test_reset;
    test_mult;
    test_mul;
    test_multu;
    test_div;
    test_div_zero;
    test_busy_ignore;
    test_flush;
    test_reset_mid;
    test_madd;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mdu_unit.md
MDU_UNIT -- requirements
Module: mdu_unit

Interface
REQ-001 The block SHALL have the port clk  input  1  single clock; all state updates on the rising edge.
REQ-002 The block SHALL have the port rst  input  1  reset, asynchronous and active-low.
REQ-003 The block SHALL have the port start  input  1  operation request from EX, valid this cycle.
REQ-004 The block SHALL have the port ALU2Op  input  4  operation code: 0001 MULT, 0010 MULTU, 0011 DIV, 0100 DIVU, 0101 MTHI, 0110 MTLO, 1000 MUL; all other codes are no-op.
REQ-005 The block SHALL have the port A  input  32  rs operand, dividend / multiplicand / MTHI-MTLO source.
REQ-006 The block SHALL have the port B  input  32  rt operand, divisor / multiplier.
REQ-007 The block SHALL have the port flush  input  1  pipeline flush (exception or eret); aborts any in-flight operation.
REQ-008 The block SHALL have the port isbusy  output  1  operation in flight; consumed by the stall unit.
REQ-009 The block SHALL have the port done  output  1  one-cycle pulse when a MUL/DIV result is committed.
REQ-010 The block SHALL have the port HI  output  32  HI register.
REQ-011 The block SHALL have the port LO  output  32  LO register.
REQ-012 The block SHALL have the port mul_result  output  32  low product word of the last MUL (code 1000); valid while done is high.

Function
REQ-013 The block SHALL implement states IDLE, MUL, DIV and FIX; isbusy SHALL be 1 exactly when state != IDLE, driven directly from the state register.
REQ-014 The block SHALL accept start only in IDLE with flush=0; start in any other state SHALL be ignored.
REQ-015 On accepting MULT/MULTU/MUL, the block SHALL latch A and B and go to MUL; the following cycle it SHALL form the 64-bit signed (MULT, MUL) or unsigned (MULTU) product, return to IDLE and pulse done.
REQ-016 On leaving MUL, MULT/MULTU SHALL write HI=product[63:32] and LO=product[31:0]; MUL SHALL write mul_result=product[31:0] and leave HI/LO unchanged.
REQ-017 On accepting DIV/DIVU, the block SHALL latch |A| and |B| (raw values for DIVU) plus the operand signs, and run 32 radix-2 restoring iterations in DIV (one quotient bit per cycle, MSB first, 5-bit iteration counter), then spend one cycle in FIX.
REQ-018 In FIX the block SHALL negate the quotient when the operand signs differ (DIV only), give the remainder the dividend's sign, write LO=quotient and HI=remainder, pulse done, and return to IDLE; isbusy SHALL be high for 33 cycles in total.
REQ-019 For DIV with A=0x80000000 and B=0xFFFFFFFF the result SHALL be LO=0x80000000 and HI=0 (two's-complement wrap).
REQ-020 For DIV/DIVU with B=0 the block SHALL still take 33 busy cycles and SHALL leave HI and LO unchanged; done SHALL pulse.
REQ-021 On an accepted MTHI (MTLO) the block SHALL write A to HI (LO) at that clock edge; isbusy SHALL stay 0 and done SHALL NOT pulse.
REQ-022 When flush=1 in any state, the next state SHALL be IDLE, no HI/LO/mul_result write SHALL occur, and done SHALL stay 0; flush SHALL take precedence over a FIX commit in the same cycle.
REQ-023 HI, LO and mul_result SHALL be registers that change only on a commit edge.

Reset
REQ-024 On rst=0, asynchronously: state=IDLE, isbusy=0, done=0, HI=0, LO=0, mul_result=0, iteration counter=0 and operand latches=0.
REQ-025 Reset asserted mid-operation SHALL discard the operation; after reset release the block SHALL accept a new start on the first clock edge.

Configuration
REQ-026 With macro MDU_MADD_EN defined, codes 1001 MADD, 1010 MADDU, 1011 MSUB and 1100 MSUBU SHALL go through MUL and commit {HI,LO} = {HI,LO} +/- product (64-bit, modulo 2^64, signed product for MADD/MSUB) with the same 1-cycle busy latency.
REQ-027 Without MDU_MADD_EN, codes 1001-1100 SHALL be no-ops: not accepted, isbusy=0, and HI/LO unchanged.

Verification
REQ-028 The bench SHALL cover: MULT A=0xFFFFFFFE, B=3 -> isbusy high 1 cycle, then HI=0xFFFFFFFF, LO=0xFFFFFFFA, and done for 1 cycle.
REQ-029 The bench SHALL cover: DIV A=-7 (0xFFFFFFF9), B=2 -> isbusy high 33 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF, and done pulses.
REQ-030 The bench SHALL cover: DIVU A=100, B=0 with HI=0x11, LO=0x22 preloaded through MTHI/MTLO -> after 33 cycles HI=0x11, LO=0x22, and done pulses.
REQ-031 The bench SHALL cover: DIVU A=100, B=7 with flush at busy cycle 10 -> IDLE next cycle, HI/LO unchanged, no done; a new MULTU 5x6 then gives LO=30.
REQ-032 The bench SHALL cover: rst=0 during DIV cycle 20 -> all outputs 0 immediately; MTLO 0xABCD after release -> LO=0xABCD.
REQ-033 The bench SHALL cover: with MDU_MADD_EN defined, HI:LO=0:0xFFFFFFFF then MADDU 1x1 -> HI=1, LO=0; without MDU_MADD_EN the same stimulus leaves HI:LO unchanged and isbusy=0.
